// File: rtl/wb_bram_arbiter.sv
`default_nettype none
// ============================================================================
// wb_bram_arbiter: two-master round-robin Wishbone (pipelined) arbiter for one BRAM port.
// Rev 1.0
// ============================================================================
module wb_bram_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int LGMAXOUT = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_m0_cyc,
  input  logic              i_m0_stb,
  input  logic              i_m0_we,
  input  logic [AW-1:0]     i_m0_addr,
  input  logic [DW-1:0]     i_m0_data,
  input  logic [DW/8-1:0]   i_m0_sel,
  output logic              o_m0_stall,
  output logic              o_m0_ack,
  output logic              o_m0_err,
  output logic [DW-1:0]     o_m0_data,
  input  logic              i_m1_cyc,
  input  logic              i_m1_stb,
  input  logic              i_m1_we,
  input  logic [AW-1:0]     i_m1_addr,
  input  logic [DW-1:0]     i_m1_data,
  input  logic [DW/8-1:0]   i_m1_sel,
  output logic              o_m1_stall,
  output logic              o_m1_ack,
  output logic              o_m1_err,
  output logic [DW-1:0]     o_m1_data,
  output logic              o_s_cyc,
  output logic              o_s_stb,
  output logic              o_s_we,
  output logic [AW-1:0]     o_s_addr,
  output logic [DW-1:0]     o_s_data,
  output logic [DW/8-1:0]   o_s_sel,
  input  logic              i_s_stall,
  input  logic              i_s_ack,
  input  logic              i_s_err,
  input  logic [DW-1:0]     i_s_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  localparam logic [LGMAXOUT:0] c_MAX_OUT = {1'b1, {LGMAXOUT{1'b0}}};
  localparam logic [LGMAXOUT:0] c_ONE     = {{LGMAXOUT{1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next;
  logic                r_last_grant;
  logic [LGMAXOUT:0]   r_outstanding;
  logic                w_full;
  logic                w_release;
  logic                w_inc;
  logic                w_dec;

  assign w_full    = (r_outstanding == c_MAX_OUT);
  assign w_release = ((r_state == S_OWN0) && !i_m0_cyc) || ((r_state == S_OWN1) && !i_m1_cyc);
  assign w_inc     = o_s_stb && !i_s_stall;
  // Late responses after an abort find the count at zero; never let them wrap it.
  assign w_dec     = (i_s_ack || i_s_err) && (r_outstanding != '0);

  assign o_m0_data = i_s_data;
  assign o_m1_data = i_s_data;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_m0_cyc && i_m1_cyc) w_next = r_last_grant ? S_OWN0 : S_OWN1;
        else if (i_m0_cyc)        w_next = S_OWN0;
        else if (i_m1_cyc)        w_next = S_OWN1;
      end
      S_OWN0:  if (!i_m0_cyc) w_next = i_m1_cyc ? S_OWN1 : S_IDLE;
      S_OWN1:  if (!i_m1_cyc) w_next = i_m0_cyc ? S_OWN0 : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_s_cyc    = 1'b0;
    o_s_stb    = 1'b0;
    o_s_we     = 1'b0;
    o_s_addr   = '0;
    o_s_data   = '0;
    o_s_sel    = '0;
    o_m0_stall = 1'b1;
    o_m0_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m1_stall = 1'b1;
    o_m1_ack   = 1'b0;
    o_m1_err   = 1'b0;
    case (r_state)
      S_OWN0: begin
        o_s_cyc    = i_m0_cyc;
        o_s_stb    = i_m0_cyc && i_m0_stb && !w_full;
        o_s_we     = i_m0_we;
        o_s_addr   = i_m0_addr;
        o_s_data   = i_m0_data;
        o_s_sel    = i_m0_sel;
        o_m0_stall = i_s_stall || w_full;
        o_m0_ack   = i_s_ack && i_m0_cyc;
        o_m0_err   = i_s_err && i_m0_cyc;
      end
      S_OWN1: begin
        o_s_cyc    = i_m1_cyc;
        o_s_stb    = i_m1_cyc && i_m1_stb && !w_full;
        o_s_we     = i_m1_we;
        o_s_addr   = i_m1_addr;
        o_s_data   = i_m1_data;
        o_s_sel    = i_m1_sel;
        o_m1_stall = i_s_stall || w_full;
        o_m1_ack   = i_s_ack && i_m1_cyc;
        o_m1_err   = i_s_err && i_m1_cyc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b1;
      r_outstanding <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_OWN0)      r_last_grant <= 1'b0;
      else if (w_next == S_OWN1) r_last_grant <= 1'b1;
      if (w_release || (r_state == S_IDLE)) r_outstanding <= '0;
      else if (w_inc && !w_dec)             r_outstanding <= r_outstanding + c_ONE;
      else if (w_dec && !w_inc)             r_outstanding <= r_outstanding - c_ONE;
    end
  end

endmodule
`default_nettype wire
